// File: rtl/board_seeder_if.sv
// Row-write channel from the board seeder into board storage.
//   row_valid : a row write is being offered
//   row_ready : the storage takes the offered write this cycle
//   row_addr  : destination row index
//   row_data  : cell bits of the row, bit j is column j
// The master modport is the seeder side and the slave modport is the storage side.
interface board_seeder_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
);
  logic             row_valid;
  logic             row_ready;
  logic [AW-1:0]    row_addr;
  logic [WIDTH-1:0] row_data;

  modport master (
    output row_valid,
    output row_addr,
    output row_data,
    input  row_ready
  );

  modport slave (
    input  row_valid,
    input  row_addr,
    input  row_data,
    output row_ready
  );
endinterface

// File: rtl/board_seeder.sv
// board_seeder: takes the 256-bit LFSR seed and loads it into the life-game
// board. An accepted start snapshots the seed through a density transform.
// The snapshot is then streamed row by row over a valid/ready write channel,
// and done pulses once after the last row has been accepted.
// WIDTH*HEIGHT must equal SEED_W.
//
// Ports:
//   clk     : system clock, rising edge
//   rst     : asynchronous reset, active-high
//   seed    : free-running LFSR value, sampled only when a start is accepted
//   start   : load request, honoured only in IDLE
//   density : transform select, sampled together with seed
//   abort   : cancels a load in progress, without a done pulse
//   rows    : row-write channel (row_valid/row_ready/row_addr/row_data)
//   busy    : high whenever the block is not idle
//   done    : single-cycle pulse after the final row is accepted
module board_seeder #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int SEED_W = 256,
  parameter int AW     = $clog2(HEIGHT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SEED_W-1:0]  seed,
  input  logic               start,
  input  logic [1:0]         density,
  input  logic               abort,
  board_seeder_if.master     rows,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [SEED_W-1:0] board_q, board_d;

  // Bit i of the result combines s[i] with its wrapped neighbour s[i+1].
  function automatic logic [SEED_W-1:0] density_xform(
    input logic [SEED_W-1:0] s,
    input logic [1:0]        d
  );
    logic [SEED_W-1:0] nxt;
    nxt = {s[0], s[SEED_W-1:1]};
    case (d)
      2'd0:    density_xform = s;
      2'd1:    density_xform = s & nxt;
      2'd2:    density_xform = s | nxt;
      default: density_xform = '0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      board_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      board_q <= board_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    board_d = board_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          board_d = density_xform(seed, density);
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Abort wins over a transfer on the same edge.
        if (abort) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (rows.row_ready) begin
          if (cnt_q == AW'(HEIGHT - 1)) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs depend only on registered state, so row_ready has no path to them.
  always_comb begin
    rows.row_valid = (state_q == S_LOAD);
    rows.row_addr  = cnt_q;
    rows.row_data  = '0;
    if (state_q == S_LOAD) begin
      rows.row_data = board_q[int'(cnt_q) * WIDTH +: WIDTH];
    end
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_board_seeder.sv
module tb_board_seeder;
  localparam int WIDTH  = 16;
  localparam int HEIGHT = 16;
  localparam int SEED_W = 256;
  localparam int AW     = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [SEED_W-1:0] seed = '0;
  logic              start = 1'b0;
  logic [1:0]        density = 2'd0;
  logic              abort = 1'b0;
  logic              busy, done;

  board_seeder_if #(.WIDTH(WIDTH), .AW(AW)) rif ();

  board_seeder #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .SEED_W(SEED_W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .seed(seed), .start(start), .density(density),
    .abort(abort), .rows(rif.master), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic [AW+WIDTH-1:0] sb[$];  // {addr, data} of rows still expected

  // Reference transform, computed bit by bit from the definition.
  function automatic logic [WIDTH-1:0] exp_row(input logic [SEED_W-1:0] s, input logic [1:0] d, input int r);
    logic [WIDTH-1:0] v;
    for (int j = 0; j < WIDTH; j++) begin
      int i;
      int n;
      i = r * WIDTH + j;
      n = (i + 1) % SEED_W;
      case (d)
        2'd0: v[j] = s[i];
        2'd1: v[j] = s[i] & s[n];
        2'd2: v[j] = s[i] | s[n];
        default: v[j] = 1'b0;
      endcase
    end
    return v;
  endfunction

  function automatic logic [SEED_W-1:0] rand_seed();
    logic [SEED_W-1:0] s;
    for (int k = 0; k < SEED_W / 32; k++) s[k*32 +: 32] = $urandom;
    return s;
  endfunction

  task automatic push_rows(input logic [SEED_W-1:0] s, input logic [1:0] d);
    for (int r = 0; r < HEIGHT; r++) sb.push_back({AW'(r), exp_row(s, d, r)});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_total++; if (rif.row_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", rif.row_valid); else n_pass++;
    n_total++; if (rif.row_addr !== '0) $display("FAIL reset_addr got %h want 0", rif.row_addr); else n_pass++;
    n_total++; if (rif.row_data !== '0) $display("FAIL reset_data got %h want 0", rif.row_data); else n_pass++;
    n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done got %b%b want 00", busy, done); else n_pass++;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    n_total++; if (busy !== 1'b0 || rif.row_valid !== 1'b0) $display("FAIL idle_after_reset busy=%b valid=%b want 0 0", busy, rif.row_valid); else n_pass++;
  endtask

  // Full-speed load: exact latency of every row, done and busy.
  task automatic test_density(input logic [1:0] d);
    logic [SEED_W-1:0] s;
    s = 256'h13253213;
    sb.delete();
    @(negedge clk);
    seed = s; density = d; start = 1'b1; rif.row_ready = 1'b1;
    push_rows(s, d);
    @(negedge clk);
    start = 1'b0; seed = rand_seed();
    for (int c = 0; c <= HEIGHT + 1; c++) begin
      if (c < HEIGHT) begin
        logic [AW+WIDTH-1:0] e;
        e = sb.pop_front();
        n_total++; if (rif.row_valid !== 1'b1 || rif.row_addr !== e[AW+WIDTH-1:WIDTH])
          $display("FAIL d%0d_addr cycle %0d got v=%b a=%0d want v=1 a=%0d", d, c, rif.row_valid, rif.row_addr, e[AW+WIDTH-1:WIDTH]); else n_pass++;
        n_total++; if (rif.row_data !== e[WIDTH-1:0])
          $display("FAIL d%0d_data row %0d got %h want %h", d, c, rif.row_data, e[WIDTH-1:0]); else n_pass++;
      end else if (c == HEIGHT) begin
        n_total++; if (done !== 1'b1 || busy !== 1'b1 || rif.row_valid !== 1'b0)
          $display("FAIL d%0d_done got done=%b busy=%b valid=%b want 1 1 0", d, done, busy, rif.row_valid); else n_pass++;
      end else begin
        n_total++; if (done !== 1'b0 || busy !== 1'b0 || rif.row_data !== '0)
          $display("FAIL d%0d_idle got done=%b busy=%b data=%h want 0 0 0", d, done, busy, rif.row_data); else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [SEED_W-1:0] s;
    logic [AW+WIDTH-1:0] held;
    int stall, ndone, c;
    s = rand_seed(); stall = 0; ndone = 0;
    sb.delete();
    @(negedge clk);
    seed = s; density = 2'd0; start = 1'b1;
    push_rows(s, 2'd0);
    @(negedge clk);
    start = 1'b0;
    for (c = 0; c < 100 && ndone == 0; c++) begin
      if (done) begin
        ndone++;
        n_total++; if (sb.size() != 0) $display("FAIL bp_early_done got %0d rows left want 0", sb.size()); else n_pass++;
      end
      if (rif.row_valid) begin
        n_total++; if ({rif.row_addr, rif.row_data} !== sb[0])
          $display("FAIL bp_row got %0d:%h want %0d:%h", rif.row_addr, rif.row_data, sb[0][AW+WIDTH-1:WIDTH], sb[0][WIDTH-1:0]); else n_pass++;
        if (rif.row_addr == AW'(5) && stall < 3) begin
          if (stall > 0) begin
            n_total++; if ({rif.row_addr, rif.row_data} !== held)
              $display("FAIL bp_stall_stable got %h want %h", {rif.row_addr, rif.row_data}, held); else n_pass++;
          end
          held = {rif.row_addr, rif.row_data};
          rif.row_ready = 1'b0;
          stall++;
        end else begin
          rif.row_ready = c[0];
        end
        if (rif.row_ready) void'(sb.pop_front());
      end else begin
        rif.row_ready = c[0];
      end
      @(negedge clk);
    end
    n_total++; if (ndone != 1 || stall != 3) $display("FAIL bp_done got done=%0d stall=%0d want 1 3", ndone, stall); else n_pass++;
    rif.row_ready = 1'b1;
  endtask

  task automatic test_seed_change();
    logic [SEED_W-1:0] s;
    int ndone, idle_seen;
    s = rand_seed(); ndone = 0; idle_seen = 0;
    sb.delete();
    @(negedge clk);
    seed = s; density = 2'd2; start = 1'b1; rif.row_ready = 1'b1;
    push_rows(s, 2'd2);
    @(negedge clk);
    for (int c = 0; c < 60 && idle_seen == 0; c++) begin
      seed = rand_seed(); density = 2'($urandom_range(0, 3));
      if (rif.row_valid) begin
        n_total++; if ({rif.row_addr, rif.row_data} !== sb[0])
          $display("FAIL seedchg_row got %0d:%h want %0d:%h", rif.row_addr, rif.row_data, sb[0][AW+WIDTH-1:WIDTH], sb[0][WIDTH-1:0]); else n_pass++;
        void'(sb.pop_front());
      end
      if (done) ndone++;
      if (!busy) begin idle_seen = 1; start = 1'b0; end  // start stays high through LOAD and DONE
      @(negedge clk);
    end
    n_total++; if (ndone != 1 || sb.size() != 0) $display("FAIL seedchg_done got done=%0d left=%0d want 1 0", ndone, sb.size()); else n_pass++;
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL seedchg_idle got busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_abort();
    logic [SEED_W-1:0] s;
    int hit, ndone;
    s = rand_seed(); hit = 0; ndone = 0;
    sb.delete();
    @(negedge clk);
    seed = s; density = 2'd0; start = 1'b1; rif.row_ready = 1'b1;
    push_rows(s, 2'd0);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 30 && hit == 0; c++) begin
      if (rif.row_valid && rif.row_addr == AW'(7)) begin abort = 1'b1; hit = 1; end
      else @(negedge clk);
    end
    @(negedge clk);
    abort = 1'b0;
    n_total++; if (hit != 1 || rif.row_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL abort_stop got hit=%0d valid=%b busy=%b done=%b want 1 0 0 0", hit, rif.row_valid, busy, done); else n_pass++;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || rif.row_valid) ndone++;
    end
    n_total++; if (ndone != 0) $display("FAIL abort_quiet got %0d active cycles want 0", ndone); else n_pass++;
    sb.delete();
    s = rand_seed();
    seed = s; density = 2'd1; start = 1'b1;
    push_rows(s, 2'd1);
    @(negedge clk);
    start = 1'b0;
    n_total++; if (rif.row_valid !== 1'b1 || rif.row_addr !== '0 || rif.row_data !== sb[0][WIDTH-1:0])
      $display("FAIL abort_restart got v=%b a=%0d d=%h want 1 0 %h", rif.row_valid, rif.row_addr, rif.row_data, sb[0][WIDTH-1:0]); else n_pass++;
    for (int c = 0; c < 40 && busy; c++) @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL abort_restart_end got busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    seed = rand_seed(); density = 2'd2; start = 1'b1; rif.row_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_total++; if (rif.row_valid !== 1'b0 || rif.row_addr !== '0 || rif.row_data !== '0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL async_rst got v=%b a=%0d d=%h busy=%b done=%b want all 0", rif.row_valid, rif.row_addr, rif.row_data, busy, done); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (busy !== 1'b0 || rif.row_valid !== 1'b0) $display("FAIL async_rst_idle got busy=%b valid=%b want 0 0", busy, rif.row_valid); else n_pass++;
  endtask

  // A start in the single IDLE cycle after DONE begins the next load at once.
  task automatic test_back_to_back();
    logic [SEED_W-1:0] a, b;
    int c;
    a = rand_seed(); b = rand_seed();
    @(negedge clk);
    seed = a; density = 2'd0; start = 1'b1; rif.row_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (c = 0; c < 40 && !done; c++) @(negedge clk);
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL b2b_gap got busy=%b want 0", busy); else n_pass++;
    sb.delete();
    seed = b; start = 1'b1;
    push_rows(b, 2'd0);
    @(negedge clk);
    start = 1'b0;
    for (c = 0; c < HEIGHT; c++) begin
      n_total++; if (rif.row_valid !== 1'b1 || {rif.row_addr, rif.row_data} !== sb[0])
        $display("FAIL b2b_row got v=%b %0d:%h want 1 %0d:%h", rif.row_valid, rif.row_addr, rif.row_data, sb[0][AW+WIDTH-1:WIDTH], sb[0][WIDTH-1:0]); else n_pass++;
      void'(sb.pop_front());
      @(negedge clk);
    end
    n_total++; if (done !== 1'b1) $display("FAIL b2b_done got %b want 1", done); else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    rif.row_ready = 1'b0;
    test_reset();
    test_density(2'd0);
    test_density(2'd1);
    test_density(2'd2);
    test_density(2'd3);
    test_backpressure();
    test_seed_change();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no end of run want finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/board_seeder.md
Name: board_seeder

Overview:
Consumes the 256-bit pseudo-random seed from the LFSR stage and loads it into the life-game cell board.
- On a start request it snapshots the seed and applies a density transform.
- It then streams the board row by row over a valid/ready write interface into the board storage or cell array.
- It pulses done after the last row and returns to idle.

Parameters:
WIDTH, 16, cells per row (row_data width).
HEIGHT, 16, number of rows. WIDTH*HEIGHT must equal SEED_W.
SEED_W, 256, seed input width, equal to the LFSR output width.
AW, $clog2(HEIGHT), row address width (4 at defaults).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous reset, active-high.
seed  in  SEED_W  free-running LFSR value, sampled only on an accepted start.
start  in  1  load request, single-cycle or level; honoured only in IDLE.
density  in  2  transform select, sampled together with seed.
abort  in  1  synchronous cancel of an in-progress load.
row_valid  out  1  row_addr/row_data hold a valid row write.
row_ready  in  1  board storage accepts the write this cycle.
row_addr  out  AW  destination row index.
row_data  out  WIDTH  cell bits for the row; bit j is column j.
busy  out  1  high whenever state != IDLE.
done  out  1  single-cycle pulse after the final row is accepted.

Behaviour:
- Reset (async, rst=1) forces:
  - state=IDLE, row counter=0, snapshot=0.
  - row_valid=0, row_addr=0, row_data=0, busy=0, done=0.
- State machine: IDLE, LOAD, DONE.
- IDLE, start=1: on that edge, latch board[i]=f(seed,density) for i=0..SEED_W-1, clear the row counter, go to LOAD.
- Density transform f, where s=seed and indices wrap mod SEED_W:
  - 0: s[i] (raw).
  - 1: s[i] & s[i+1] (sparse).
  - 2: s[i] | s[i+1] (dense).
  - 3: 0 (clear board).
- LOAD outputs:
  - row_valid=1, row_addr=counter, row_data=board[counter*WIDTH +: WIDTH].
  - Outputs are registered or derived only from state/counter/snapshot; there is no combinational path from row_ready.
- Transfer occurs when row_valid and row_ready are both high on a clock edge.
  - Not last row: increment the counter.
  - Counter==HEIGHT-1: go to DONE.
  - row_valid=1 with row_ready=0: addr and data hold stable, no limit on stall length.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. Once back in IDLE, row_valid=0 and row_data=0.
- Latency, with start at edge t and row_ready held at 1:
  - row k valid during cycle t+1+k.
  - done during cycle t+1+HEIGHT.
  - busy low from cycle t+2+HEIGHT.
  - A start in that IDLE cycle is accepted (back-to-back loads permitted).
- Start while busy (LOAD or DONE): ignored; the snapshot is not re-sampled.
- Abort in LOAD: next state IDLE, counter=0, no done pulse.
  - Abort has priority over a simultaneous transfer; that row counts as not written by this block.
  - Abort in IDLE or DONE has no effect.
- Async reset mid-LOAD: immediate return to reset values. The board may be partially written; no done.
- Snapshot is constant for the whole load, independent of seed changes after capture.

Test Plan:
1. Reset then start, seed=256'h13253213, density=0, row_ready=1 -> row0=16'h3213, row1=16'h1325, rows 2..15=0, addrs 0..15 on consecutive cycles, done one cycle after row15, busy low the next cycle.
2. Same seed, density=1 -> row0=16'h1001, row1=16'h0100, rest 0. Density=2 -> row0=16'hBB1B, row1=16'h1BB7, rest 0. Density=3 -> all 16 rows 0.
3. Backpressure: row_ready low for 3 cycles on row 5 and toggling elsewhere -> row 5 addr/data stable while stalled, each row written exactly once in order, done only after row 15 is accepted.
4. Seed changes every cycle after start, and start is re-asserted during LOAD and DONE -> streamed data matches the seed at the capture edge only, and exactly one done.
5. Abort asserted with row_ready=1 while row_addr=7 -> no further row_valid, no done, busy low next cycle; a new start then loads rows from 0.
6. rst asserted asynchronously mid-LOAD, between clock edges -> all outputs 0 immediately; after release the block idles until start.
